// File: rtl/csla_pkg.sv
// Shared constants and types for the csla_64bit adder and its accumulator.
// CSLA_ACC_SAT_EN selects saturating accumulation in csla_acc_64bit.
package csla_pkg;

   localparam int DATA_W = 64;

   localparam logic [DATA_W-1:0] SAT_VAL = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/csla_64bit.sv
// Combinational 64-bit carry-select adder built from 4-bit blocks.
// Each block precomputes both carry-in cases; the ripple only drives the muxes.
module csla_64bit
   import csla_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   output logic [DATA_W-1:0] sum,
   output logic              cout
);

   localparam int BLK = 4;
   localparam int NB  = DATA_W / BLK;

   logic [NB:0] c;

   assign c[0] = cin;

   for (genvar g = 0; g < NB; g++) begin : g_blk
      logic [BLK:0] s0;
      logic [BLK:0] s1;

      assign s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
      assign s1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]}
                  + (BLK+1)'(1);

      assign sum[g*BLK +: BLK] = c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
      assign c[g+1]            = c[g] ? s1[BLK]     : s0[BLK];
   end

   assign cout = c[NB];

endmodule

// File: rtl/csla_acc_64bit.sv
// Burst accumulator around a single csla_64bit, with sticky overflow flag.
// Define CSLA_ACC_SAT_EN to saturate at all-ones instead of wrapping.
module csla_acc_64bit
   import csla_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_terms,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] acc_out,
   output logic              ovf
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [DATA_W-1:0] add_sum;
   logic              add_cout;
   logic              beat;

   csla_64bit u_add (
      .a    (acc_q),
      .b    (in_data),
      .cin  (in_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == DONE);
   assign beat      = in_valid && in_ready;
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = num_terms;
               state_d = (num_terms != '0) ? ACC : DONE;
            end
         end
         ACC: begin
            if (beat) begin
`ifdef CSLA_ACC_SAT_EN
               // Once saturated, stay pinned at all-ones for the burst
               if (add_cout || (ovf_q && acc_q == SAT_VAL)) begin
                  acc_d = SAT_VAL;
                  ovf_d = 1'b1;
               end else begin
                  acc_d = add_sum;
                  ovf_d = ovf_q;
               end
`else
               acc_d = add_sum;
               ovf_d = ovf_q | add_cout;
`endif
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_csla_acc_64bit.sv
// Directed testbench for csla_acc_64bit.
// Inputs change on the falling edge; outputs are checked there too.
module tb_csla_acc_64bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  num_terms;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] acc_out;
   logic        ovf;

   int checks;
   int errors;

   csla_acc_64bit #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_terms (num_terms),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_out   (acc_out),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic start_burst(input logic [7:0] n);
      @(negedge clk);
      start     = 1'b1;
      num_terms = n;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic put_beat(input logic [63:0] d, input logic c);
      in_valid = 1'b1;
      in_data  = d;
      in_cin   = c;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic finish_out;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #12;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 ||
          acc_out !== 64'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b acc=%0d ovf=%b, want 0 0 0 0",
                  in_ready, out_valid, acc_out, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_hs: rdy=%b vld=%b, want 0 0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_basic;
      start_burst(8'd2);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_rdy: in_ready=%b, want 1", in_ready);
      end
      put_beat(64'd10, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early: out_valid=%b, want 0", out_valid);
      end
      put_beat(64'd35, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || acc_out !== 64'd45 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL basic_sum: vld=%b acc=%0d ovf=%b, want 1 45 0",
                  out_valid, acc_out, ovf);
      end
      finish_out();
      checks++;
      if (out_valid !== 1'b0 || acc_out !== 64'd45) begin
         errors++;
         $display("FAIL basic_idle: vld=%b acc=%0d, want 0 45",
                  out_valid, acc_out);
      end
   endtask

   task automatic test_gap;
      start_burst(8'd3);
      put_beat(64'd23, 1'b1);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (in_ready !== 1'b1 || acc_out !== 64'd24) begin
            errors++;
            $display("FAIL gap_hold: rdy=%b acc=%0d, want 1 24",
                     in_ready, acc_out);
         end
         @(negedge clk);
      end
      put_beat(64'd132, 1'b0);
      put_beat(64'd3846, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || acc_out !== 64'd4002 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL gap_sum: vld=%b acc=%0d ovf=%b, want 1 4002 0",
                  out_valid, acc_out, ovf);
      end
      finish_out();
   endtask

   task automatic test_overflow;
      logic [63:0] exp_acc;
`ifdef CSLA_ACC_SAT_EN
      exp_acc = 64'hFFFF_FFFF_FFFF_FFFF;
`else
      exp_acc = 64'd1;
`endif
      start_burst(8'd2);
      put_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      put_beat(64'd2, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || acc_out !== exp_acc || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sum: vld=%b acc=%h ovf=%b, want 1 %h 1",
                  out_valid, acc_out, ovf, exp_acc);
      end
      finish_out();
   endtask

   task automatic test_zero_terms;
      start_burst(8'd0);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          acc_out !== 64'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL zero: vld=%b rdy=%b acc=%0d ovf=%b, want 1 0 0 0",
                  out_valid, in_ready, acc_out, ovf);
      end
      finish_out();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_idle: out_valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_backpressure;
      start_burst(8'd2);
      put_beat(64'd5, 1'b0);
      put_beat(64'd7, 1'b0);
      for (int i = 0; i < 5; i++) begin
         start     = (i == 2);
         num_terms = 8'd3;
         checks++;
         if (out_valid !== 1'b1 || acc_out !== 64'd12 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: vld=%b acc=%0d rdy=%b, want 1 12 0",
                     i, out_valid, acc_out, in_ready);
         end
         @(negedge clk);
      end
      start = 1'b0;
      finish_out();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || acc_out !== 64'd12) begin
         errors++;
         $display("FAIL bp_idle: vld=%b rdy=%b acc=%0d, want 0 0 12",
                  out_valid, in_ready, acc_out);
      end
   endtask

   task automatic test_reset_mid_burst;
      start_burst(8'd3);
      put_beat(64'd866945, 1'b1);
      checks++;
      if (acc_out !== 64'd866946 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_acc: acc=%0d rdy=%b, want 866946 1",
                  acc_out, in_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (acc_out !== 64'd0 || ovf !== 1'b0 ||
          in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst: acc=%0d ovf=%b rdy=%b vld=%b, want 0 0 0 0",
                  acc_out, ovf, in_ready, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      start_burst(8'd2);
      put_beat(64'd3846, 1'b0);
      put_beat(64'd9654, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || acc_out !== 64'd13500 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL mid_new: vld=%b acc=%0d ovf=%b, want 1 13500 0",
                  out_valid, acc_out, ovf);
      end
      finish_out();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      start     = 1'b0;
      num_terms = 8'd0;
      in_valid  = 1'b0;
      in_data   = 64'd0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_gap();
      test_overflow();
      test_zero_terms();
      test_backpressure();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csla_acc_64bit.md
Name: csla_acc_64bit

Overview:
- Sequential accumulator stage directly downstream of the combinational csla_64bit adder; a single csla_64bit instance performs every addition.
- Accepts a counted burst of 64-bit operands over a valid/ready handshake and adds each into a 64-bit accumulator, along with a per-beat carry-in.
- Presents the final sum plus a sticky overflow flag over an output valid/ready handshake.

Parameters:
- CNT_W, 8, width of the term counter; a burst holds 0 to 2^CNT_W-1 terms.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a burst; sampled only in IDLE.
- num_terms  input  CNT_W  number of operands in the burst; sampled with start.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  64  operand.
- in_cin  input  1  carry-in added with this operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- acc_out  output  64  accumulated sum.
- ovf  output  1  sticky: set if any addition in the burst produced cout=1.

Behaviour:
- Reset (async, any state, including mid-burst): state=IDLE, acc_out=0, ovf=0, count=0, in_ready=0, out_valid=0. Partial results are discarded.
- States: IDLE, ACC, DONE, encoded 2 bits.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 and num_terms>0: acc<=0, ovf<=0, count<=num_terms, next state ACC.
  - start=1 and num_terms=0: acc<=0, ovf<=0, next state DONE.
- ACC:
  - in_ready=1 combinationally; out_valid=0.
  - A beat is accepted when in_valid&&in_ready. On acceptance: acc<=sum from csla_64bit(a=acc, b=in_data, cin=in_cin); ovf<=ovf|cout; count<=count-1.
  - Accepting the beat with count=1 transitions to DONE.
  - Idle cycles (in_valid=0) leave all state unchanged.
  - start is ignored.
- DONE:
  - out_valid=1; acc_out and ovf held stable.
  - out_ready=1: next state IDLE, out_valid falls the next cycle. out_ready may be held high in advance.
  - start is ignored.
- Latency: out_valid asserts on the cycle after the last beat is accepted; throughput is 1 beat/cycle.
- Arithmetic: modulo 2^64. The adder carry-out feeds only ovf and never extends acc.
- acc_out and ovf are registered outputs, visible in every state. They hold the last result after the return to IDLE until the next start.

Optional Feature:
- Macro CSLA_ACC_SAT_EN.
- Defined: saturating accumulate. If an accepted beat produces cout=1, or acc is already saturated with ovf=1, then acc<=64'hFFFF_FFFF_FFFF_FFFF and ovf<=1. The accumulator stays at all-ones for the rest of the burst.
- Undefined: wrap-around modulo 2^64 as specified above; ovf is still reported.

Decomposition:
- Shared package csla_pkg holds:
  - DATA_W=64 constant.
  - State typedef: IDLE=2'd0, ACC=2'd1, DONE=2'd2.
  - SAT_VAL=64'hFFFF_FFFF_FFFF_FFFF constant.
- Sub-module: the existing csla_64bit, instantiated once, combinational. There are no other sub-modules; the FSM, counter and registers stay in the top level.

Test Plan:
- start, num_terms=2; beats 10/cin0, 35/cin0 -> out_valid 1 cycle after second beat, acc_out=45, ovf=0.
- num_terms=3; beats 23/cin1, 132/cin0, 3846/cin0 with a 2-cycle in_valid gap -> acc_out=4002, ovf=0; in_ready stays 1 through the gap.
- num_terms=2; beats 64'hFFFF_FFFF_FFFF_FFFF/cin0, 2/cin0 -> acc_out=1, ovf=1. With CSLA_ACC_SAT_EN: acc_out=64'hFFFF_FFFF_FFFF_FFFF, ovf=1.
- num_terms=0 -> DONE on the next cycle, acc_out=0, ovf=0, no beat accepted (in_ready stays 0).
- Output backpressure: out_ready=0 for 5 cycles -> out_valid and acc_out stable. A start pulse during DONE is ignored. out_ready=1 -> IDLE the next cycle.
- Reset mid-burst: assert rst after the first of 3 beats (866945/cin1) -> outputs immediately 0 and state IDLE. A new burst of 3846 and 9654 -> acc_out=13500.
